// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage
// Registered RV32I decode stage between fetch and execute. Decodes one instruction + PC per
// valid/ready handshake into the ALU func code, operand selects, immediate, register indices and
// instruction kind. The result sits in a single-entry output register until execute accepts it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop the held bundle and any same-cycle input
//   in_valid/in_ready   fetch handshake; in_inst, in_pc are the offered instruction and address
//   out_valid/out_ready execute handshake
//   out_pc, out_func, out_op1_sel, out_op2_sel, out_imm, out_rs1, out_rs2, out_rd, out_rd_we,
//   out_kind, out_funct3  decoded bundle fields
module alu_ctrl_decode_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_func,
  output logic [1:0]      out_op1_sel,
  output logic [1:0]      out_op2_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [2:0]      out_kind,
  output logic [2:0]      out_funct3
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] FuncAdd  = 4'b0000;
  localparam logic [3:0] FuncSub  = 4'b1000;
  localparam logic [3:0] FuncSlt  = 4'b0010;
  localparam logic [3:0] FuncSltu = 4'b0011;
  localparam logic [3:0] FuncOp2  = 4'b1001;
  localparam logic [3:0] FuncZero = 4'b1011;

  localparam logic [1:0] Op1Rs1  = 2'b00;
  localparam logic [1:0] Op1Pc   = 2'b01;
  localparam logic [1:0] Op1Zero = 2'b10;
  localparam logic [1:0] Op2Rs2  = 2'b00;
  localparam logic [1:0] Op2Imm  = 2'b01;
  localparam logic [1:0] Op2Four = 2'b10;

  localparam logic [2:0] KindAlu    = 3'd0;
  localparam logic [2:0] KindLoad   = 3'd1;
  localparam logic [2:0] KindStore  = 3'd2;
  localparam logic [2:0] KindBranch = 3'd3;
  localparam logic [2:0] KindJal    = 3'd4;
  localparam logic [2:0] KindJalr   = 3'd5;
  localparam logic [2:0] KindUpper  = 3'd6;
  localparam logic [2:0] KindIll    = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      func;
    logic [1:0]      op1_sel;
    logic [1:0]      op2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [2:0]      kind;
    logic [2:0]      funct3;
  } bundle_t;

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                  1'b0};

  bundle_t dec;
  logic    legal, we;

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.funct3 = funct3;
    dec.func   = FuncAdd;
    dec.kind   = KindAlu;
    legal      = 1'b1;
    we         = 1'b0;
    unique case (opcode)
      OpReg: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.func = {funct7[5], funct3};
        dec.rs1  = rs1;
        dec.rs2  = rs2;
        we       = 1'b1;
      end
      OpImm: begin
        // Only srai carries an op modifier (imm[10]); shifts reuse imm[11:5] as funct7.
        dec.func = (funct3 == 3'b101) ? {in_inst[30], funct3} : {1'b0, funct3};
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
        dec.op2_sel = Op2Imm;
        dec.imm     = imm_i;
        dec.rs1     = rs1;
        we          = 1'b1;
      end
      OpLui: begin
        dec.func    = FuncOp2;
        dec.op1_sel = Op1Zero;
        dec.op2_sel = Op2Imm;
        dec.imm     = imm_u;
        dec.kind    = KindUpper;
        we          = 1'b1;
      end
      OpAuipc: begin
        dec.op1_sel = Op1Pc;
        dec.op2_sel = Op2Imm;
        dec.imm     = imm_u;
        dec.kind    = KindUpper;
        we          = 1'b1;
      end
      OpJal: begin
        dec.op1_sel = Op1Pc;
        dec.op2_sel = Op2Four;
        dec.imm     = imm_j;
        dec.kind    = KindJal;
        we          = 1'b1;
      end
      OpJalr: begin
        legal       = (funct3 == 3'b000);
        dec.op1_sel = Op1Pc;
        dec.op2_sel = Op2Four;
        dec.imm     = imm_i;
        dec.rs1     = rs1;
        dec.kind    = KindJalr;
        we          = 1'b1;
      end
      OpLoad: begin
        dec.op1_sel = Op1Rs1;
        dec.op2_sel = Op2Imm;
        dec.imm     = imm_i;
        dec.rs1     = rs1;
        dec.kind    = KindLoad;
        we          = 1'b1;
      end
      OpStore: begin
        dec.op2_sel = Op2Imm;
        dec.imm     = imm_s;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.kind    = KindStore;
      end
      OpBranch: begin
        case (funct3)
          3'b000, 3'b001: dec.func = FuncSub;
          3'b100, 3'b101: dec.func = FuncSlt;
          3'b110, 3'b111: dec.func = FuncSltu;
          default:        legal    = 1'b0;
        endcase
        dec.op2_sel = Op2Rs2;
        dec.imm     = imm_b;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.kind    = KindBranch;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec        = '0;
      dec.pc     = in_pc;
      dec.funct3 = funct3;
      dec.func   = FuncZero;
      dec.kind   = KindIll;
      we         = 1'b0;
    end
    dec.rd_we = we && (rd != 5'd0);
    dec.rd    = dec.rd_we ? rd : 5'd0;
  end

  // Output register and handshake
  bundle_t bundle_q, bundle_d, bundle_rst;
  logic    valid_q, valid_d;
  logic    accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    bundle_rst      = '0;
    bundle_rst.pc   = RESET_PC;
    bundle_rst.func = FuncZero;
    bundle_rst.kind = KindIll;
  end

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= bundle_rst;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = bundle_q.pc;
  assign out_func    = bundle_q.func;
  assign out_op1_sel = bundle_q.op1_sel;
  assign out_op2_sel = bundle_q.op2_sel;
  assign out_imm     = bundle_q.imm;
  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_rd      = bundle_q.rd;
  assign out_rd_we   = bundle_q.rd_we;
  assign out_kind    = bundle_q.kind;
  assign out_funct3  = bundle_q.funct3;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Scoreboard bench for alu_ctrl_decode_stage: the driver pushes the hand-computed bundle for every
// accepted instruction; the monitor compares the presented bundle on every cycle out_valid is high
// and pops it when execute takes it.
module tb_alu_ctrl_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  func;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  kind;
    logic [2:0]  f3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_imm;
  logic [3:0]  out_func;
  logic [1:0]  out_op1_sel, out_op2_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we;
  logic [2:0]  out_kind, out_funct3;

  int n_vec  = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  alu_ctrl_decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_func   (out_func),
    .out_op1_sel(out_op1_sel),
    .out_op2_sel(out_op2_sel),
    .out_imm    (out_imm),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .out_kind   (out_kind),
    .out_funct3 (out_funct3)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] func,
                              input logic [1:0] op1, input logic [1:0] op2,
                              input logic [31:0] imm, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                              input logic [2:0] kind, input logic [2:0] f3);
    return {pc, func, op1, op2, imm, rs1, rs2, rd, we, kind, f3};
  endfunction

  function automatic exp_t dut_bundle();
    return {out_pc, out_func, out_op1_sel, out_op2_sel, out_imm, out_rs1, out_rs2, out_rd,
            out_rd_we, out_kind, out_funct3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chk_bundle(input string name, input exp_t act, input exp_t req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Offer one instruction; push its expected bundle once the stage accepts it.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    int waited = 0;
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          chk_bundle("unexpected_out", dut_bundle(), '0);
          if (dut_bundle() === '0) begin
            n_fail++;
            $display("FAIL unexpected_out: got out_valid=1, required 0");
          end
        end else begin
          chk_bundle("bundle", dut_bundle(), exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycles(3);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk_bundle("rst_bundle", dut_bundle(), mk(32'h0, 4'hb, 2'd0, 2'd0, 32'h0, 5'd0, 5'd0,
                                              5'd0, 1'b0, 3'd7, 3'd0));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    cycles(1);

    // Back-to-back decode vectors, full throughput
    out_ready = 1'b1;
    send(32'h402081B3, 32'h100, mk(32'h100, 4'h8, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1,
                                   3'd0, 3'd0));                                     // sub
    send(32'h40335293, 32'h104, mk(32'h104, 4'hd, 2'd0, 2'd1, 32'h403, 5'd6, 5'd0, 5'd5, 1'b1,
                                   3'd0, 3'd5));                                     // srai
    send(32'h02331293, 32'h108, mk(32'h108, 4'hb, 2'd0, 2'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0,
                                   3'd7, 3'd1));                                     // bad slli
    send(32'h008000EF, 32'h200, mk(32'h200, 4'h0, 2'd1, 2'd2, 32'h8, 5'd0, 5'd0, 5'd1, 1'b1,
                                   3'd4, 3'd0));                                     // jal
    send(32'hFFF00393, 32'h204, mk(32'h204, 4'h0, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd7,
                                   1'b1, 3'd0, 3'd0));                               // addi -1
    send(32'h12345237, 32'h208, mk(32'h208, 4'h9, 2'd2, 2'd1, 32'h12345000, 5'd0, 5'd0, 5'd4,
                                   1'b1, 3'd6, 3'd5));                               // lui
    send(32'h00001117, 32'h20C, mk(32'h20C, 4'h0, 2'd1, 2'd1, 32'h1000, 5'd0, 5'd0, 5'd2, 1'b1,
                                   3'd6, 3'd1));                                     // auipc
    send(32'hFE208EE3, 32'h210, mk(32'h210, 4'h8, 2'd0, 2'd0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0,
                                   1'b0, 3'd3, 3'd0));                               // beq -4
    send(32'h00512623, 32'h214, mk(32'h214, 4'h0, 2'd0, 2'd1, 32'hC, 5'd2, 5'd5, 5'd0, 1'b0,
                                   3'd2, 3'd2));                                     // sw
    send(32'h00208033, 32'h218, mk(32'h218, 4'h0, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd0, 1'b0,
                                   3'd0, 3'd0));                                     // add x0
    send(32'h00002063, 32'h21C, mk(32'h21C, 4'hb, 2'd0, 2'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0,
                                   3'd7, 3'd2));                                     // bad branch
    send(32'hFF84A303, 32'h220, mk(32'h220, 4'h0, 2'd0, 2'd1, 32'hFFFFFFF8, 5'd9, 5'd0, 5'd6,
                                   1'b1, 3'd1, 3'd2));                               // lw
    send(32'h004280E7, 32'h224, mk(32'h224, 4'h0, 2'd1, 2'd2, 32'h4, 5'd5, 5'd0, 5'd1, 1'b1,
                                   3'd5, 3'd0));                                     // jalr
    cycles(3);
    chk("drain_q", 64'(exp_q.size()), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Back-pressure: held bundle is compared by the monitor every stalled cycle
    out_ready = 1'b0;
    send(32'h402081B3, 32'h300, mk(32'h300, 4'h8, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1,
                                   3'd0, 3'd0));
    in_inst  = 32'h40335293;
    in_pc    = 32'h304;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h40335293, 32'h304, mk(32'h304, 4'hd, 2'd0, 2'd1, 32'h403, 5'd6, 5'd0, 5'd5, 1'b1,
                                   3'd0, 3'd5));
    send(32'h008000EF, 32'h308, mk(32'h308, 4'h0, 2'd1, 2'd2, 32'h8, 5'd0, 5'd0, 5'd1, 1'b1,
                                   3'd4, 3'd0));
    send(32'h00512623, 32'h30C, mk(32'h30C, 4'h0, 2'd0, 2'd1, 32'hC, 5'd2, 5'd5, 5'd0, 1'b0,
                                   3'd2, 3'd2));
    cycles(3);
    chk("bp_drain_q", 64'(exp_q.size()), 64'd0);

    // Flush alongside an acceptable input: nothing delivered
    in_inst  = 32'h402081B3;
    in_pc    = 32'h400;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    cycles(2);

    // Flush of a held bundle
    out_ready = 1'b0;
    send(32'hFFF00393, 32'h404, mk(32'h404, 4'h0, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd7,
                                   1'b1, 3'd0, 3'd0));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_held_valid", 64'(out_valid), 64'd0);
    cycles(2);

    // Reset with a held bundle
    send(32'h008000EF, 32'h500, mk(32'h500, 4'h0, 2'd1, 2'd2, 32'h8, 5'd0, 5'd0, 5'd1, 1'b1,
                                   3'd4, 3'd0));
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_func", 64'(out_func), 64'hb);
    chk("mid_rst_pc", 64'(out_pc), 64'h0);
    chk("mid_rst_kind", 64'(out_kind), 64'd7);
    rst       = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    chk("final_q", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
